// File: rtl/sdp_asym_pkg.sv
// Shared types and width helpers for the asymmetric simple-dual-port RAM.
// Wide address W, lane k always maps to narrow address {W, k}.
package sdp_asym_pkg;

    typedef enum logic [0:0] {
        SDP_NW_WR = 1'b0,
        SDP_WW_RN = 1'b1
    } sdp_mode_e;

    localparam int SDP_MAX_RATIO_LOG2 = 3;

    function automatic int calc_ratio(input int ratio_log2);
        return int'(32'd1 << ratio_log2);
    endfunction

    function automatic int calc_we_w(input int mode, input int ratio_log2);
        return (mode == int'(SDP_WW_RN)) ? calc_ratio(ratio_log2) : 1;
    endfunction

    function automatic int calc_wa_w(input int mode, input int abits, input int ratio_log2);
        return (mode == int'(SDP_WW_RN)) ? (abits - ratio_log2) : abits;
    endfunction

    function automatic int calc_wd_w(input int mode, input int dbits, input int ratio_log2);
        return (mode == int'(SDP_WW_RN)) ? (dbits * calc_ratio(ratio_log2)) : dbits;
    endfunction

    function automatic int calc_ra_w(input int mode, input int abits, input int ratio_log2);
        return (mode == int'(SDP_WW_RN)) ? abits : (abits - ratio_log2);
    endfunction

    function automatic int calc_rd_w(input int mode, input int dbits, input int ratio_log2);
        return (mode == int'(SDP_WW_RN)) ? dbits : (dbits * calc_ratio(ratio_log2));
    endfunction

    function automatic logic [31:0] lane_addr(input logic [31:0] wide_addr,
                                              input int lane,
                                              input int ratio_log2);
        return (wide_addr << ratio_log2) | 32'(lane);
    endfunction

endpackage

// File: rtl/sdp_asym_rd_pipe.sv
// Read output register(s) and rd_valid pipeline of sdp_asym_ram.
// SDP_ASYM_OUTREG_EN adds a second output stage (read latency 2).
module sdp_asym_rd_pipe #(
    parameter int RD_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            re_i,
    input  logic [RD_W-1:0] rd_word_i,
    output logic [RD_W-1:0] rd_o,
    output logic            rd_valid_o
);

    logic [RD_W-1:0] rd1_q;
    logic [RD_W-1:0] rd1_d;
    logic            v1_q;

    // First stage captures the array word on an accepted read, otherwise holds.
    always_comb begin
        if (re_i) begin
            rd1_d = rd_word_i;
        end else begin
            rd1_d = rd1_q;
        end
    end

    // First stage data and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            rd1_q <= rd1_d;
            v1_q  <= re_i;
        end
    end

`ifdef SDP_ASYM_OUTREG_EN
    logic [RD_W-1:0] rd2_q;
    logic [RD_W-1:0] rd2_d;
    logic            v2_q;

    // Second stage follows the first only when it carries fresh data.
    always_comb begin
        if (v1_q) begin
            rd2_d = rd1_q;
        end else begin
            rd2_d = rd2_q;
        end
    end

    // Second stage data and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd2_q <= '0;
            v2_q  <= 1'b0;
        end else begin
            rd2_q <= rd2_d;
            v2_q  <= v1_q;
        end
    end

    assign rd_o       = rd2_q;
    assign rd_valid_o = v2_q;
`else
    assign rd_o       = rd1_q;
    assign rd_valid_o = v1_q;
`endif

endmodule

// File: rtl/sdp_asym_ram.sv
// Simple-dual-port RAM with a narrow and a wide port; MODE picks which side writes.
// Optional macro SDP_ASYM_OUTREG_EN adds an output register stage (see sdp_asym_rd_pipe).
module sdp_asym_ram
    import sdp_asym_pkg::*;
#(
    parameter  int ABITS      = 10,
    parameter  int DBITS      = 8,
    parameter  int RATIO_LOG2 = 2,
    parameter  int MODE       = 0,
    localparam int WE_W       = calc_we_w(MODE, RATIO_LOG2),
    localparam int WA_W       = calc_wa_w(MODE, ABITS, RATIO_LOG2),
    localparam int WD_W       = calc_wd_w(MODE, DBITS, RATIO_LOG2),
    localparam int RA_W       = calc_ra_w(MODE, ABITS, RATIO_LOG2),
    localparam int RD_W       = calc_rd_w(MODE, DBITS, RATIO_LOG2)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WE_W-1:0] we,
    input  logic [WA_W-1:0] wa,
    input  logic [WD_W-1:0] wd,
    input  logic            re,
    input  logic [RA_W-1:0] ra,
    output logic [RD_W-1:0] rd,
    output logic            rd_valid
);

    localparam int RATIO = calc_ratio(RATIO_LOG2);
    localparam int DEPTH = int'(32'd1 << ABITS);

    if ((RATIO_LOG2 > SDP_MAX_RATIO_LOG2) || (RATIO_LOG2 >= ABITS)) begin : g_bad_ratio
        $error("sdp_asym_ram: RATIO_LOG2 must be <= 3 and < ABITS");
    end
    if ((MODE != int'(SDP_NW_WR)) && (MODE != int'(SDP_WW_RN))) begin : g_bad_mode
        $error("sdp_asym_ram: MODE must be 0 or 1");
    end

    // Contents are deliberately left unreset.
    logic [DBITS-1:0] mem_q [DEPTH];
    logic [RD_W-1:0]  rd_word_s;

    if (MODE == int'(SDP_NW_WR)) begin : g_nw_wr
        // Narrow write; writes are suppressed while reset is asserted.
        always_ff @(posedge clk) begin
            if (rst_n && we[0]) begin
                mem_q[wa] <= wd;
            end
        end

        // Wide read assembles lane k from narrow word {ra, k}.
        always_comb begin
            rd_word_s = '0;
            for (int k = 0; k < RATIO; k++) begin
                rd_word_s[k*DBITS +: DBITS] = mem_q[ABITS'(lane_addr(32'(ra), k, RATIO_LOG2))];
            end
        end
    end else begin : g_ww_rn
        // Wide write with per-lane mask; writes are suppressed while reset is asserted.
        always_ff @(posedge clk) begin
            if (rst_n) begin
                for (int k = 0; k < RATIO; k++) begin
                    if (we[k]) begin
                        mem_q[ABITS'(lane_addr(32'(wa), k, RATIO_LOG2))] <= wd[k*DBITS +: DBITS];
                    end
                end
            end
        end

        // Narrow read straight from the array.
        always_comb begin
            rd_word_s = mem_q[ra];
        end
    end

    // Read data is sampled from the pre-write array contents, giving read-first collisions.
    sdp_asym_rd_pipe #(
        .RD_W(RD_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .re_i      (re),
        .rd_word_i (rd_word_s),
        .rd_o      (rd),
        .rd_valid_o(rd_valid)
    );

endmodule

// File: tb/tb_sdp_asym_ram.sv
// Bench for sdp_asym_ram: one MODE 0 and one MODE 1 instance (ABITS=6, DBITS=8, ratio 4)
// checked every cycle against a word-array model, plus directed literal checks.
module tb_sdp_asym_ram;

`ifdef SDP_ASYM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        we0;
    logic [5:0]  wa0;
    logic [7:0]  wd0;
    logic        re0;
    logic [3:0]  ra0;
    logic [31:0] rd0;
    logic        v0;
    logic [3:0]  we1;
    logic [3:0]  wa1;
    logic [31:0] wd1;
    logic        re1;
    logic [5:0]  ra1;
    logic [7:0]  rd1;
    logic        v1;

    int vectors = 0;
    int errors  = 0;

    // Model: narrow word arrays with a "written since power-up" flag per word.
    logic [7:0] mm0 [64];
    logic [7:0] mm1 [64];
    bit         mk0 [64];
    bit         mk1 [64];

    // Expected pipeline contents; masks mark lanes whose value is known.
    logic [31:0] e0_rd1, e0_rd2;
    logic [3:0]  e0_m1, e0_m2;
    bit          e0_v1, e0_v2;
    logic [7:0]  e1_rd1, e1_rd2;
    bit          e1_m1, e1_m2;
    bit          e1_v1, e1_v2;

    sdp_asym_ram #(.ABITS(6), .DBITS(8), .RATIO_LOG2(2), .MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .we(we0), .wa(wa0), .wd(wd0),
        .re(re0), .ra(ra0), .rd(rd0), .rd_valid(v0)
    );

    sdp_asym_ram #(.ABITS(6), .DBITS(8), .RATIO_LOG2(2), .MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .we(we1), .wa(wa1), .wd(wd1),
        .re(re1), .ra(ra1), .rd(rd1), .rd_valid(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_model_outputs();
        e0_rd1 = '0; e0_rd2 = '0; e0_m1 = 4'hF; e0_m2 = 4'hF; e0_v1 = 1'b0; e0_v2 = 1'b0;
        e1_rd1 = '0; e1_rd2 = '0; e1_m1 = 1'b1; e1_m2 = 1'b1; e1_v1 = 1'b0; e1_v2 = 1'b0;
    endtask

    task automatic idle();
        we0 = 1'b0; re0 = 1'b0; we1 = 4'h0; re1 = 1'b0;
    endtask

    // Compare both DUTs against the model's output stage.
    task automatic compare();
        logic [31:0] x0, bm0;
        logic [3:0]  m0;
        logic [7:0]  x1;
        bit          m1, xv0, xv1;
        x0  = (LAT == 2) ? e0_rd2 : e0_rd1;
        m0  = (LAT == 2) ? e0_m2  : e0_m1;
        xv0 = (LAT == 2) ? e0_v2  : e0_v1;
        x1  = (LAT == 2) ? e1_rd2 : e1_rd1;
        m1  = (LAT == 2) ? e1_m2  : e1_m1;
        xv1 = (LAT == 2) ? e1_v2  : e1_v1;
        bm0 = {{8{m0[3]}}, {8{m0[2]}}, {8{m0[1]}}, {8{m0[0]}}};
        if (m0 != 4'h0) begin
            vectors++;
            if (((rd0 ^ x0) & bm0) != 32'h0) begin
                errors++;
                $display("FAIL model_rd0: got %h, expected %h (lane mask %b)", rd0, x0, m0);
            end
        end
        chk("model_v0", 32'(v0), 32'(xv0));
        if (m1) begin
            chk("model_rd1", 32'(rd1), 32'(x1));
        end
        chk("model_v1", 32'(v1), 32'(xv1));
    endtask

    // Apply one clock edge to model and DUT, then compare.
    task automatic step();
        if (!rst_n) begin
            clear_model_outputs();
        end else begin
            if (e0_v1) begin e0_rd2 = e0_rd1; e0_m2 = e0_m1; end
            e0_v2 = e0_v1;
            if (e1_v1) begin e1_rd2 = e1_rd1; e1_m2 = e1_m1; end
            e1_v2 = e1_v1;
            if (re0) begin
                for (int k = 0; k < 4; k++) begin
                    e0_rd1[k*8 +: 8] = mm0[ra0 * 4 + k];
                    e0_m1[k]         = mk0[ra0 * 4 + k];
                end
            end
            e0_v1 = re0;
            if (re1) begin
                e1_rd1 = mm1[ra1];
                e1_m1  = mk1[ra1];
            end
            e1_v1 = re1;
            if (we0) begin
                mm0[wa0] = wd0;
                mk0[wa0] = 1'b1;
            end
            for (int k = 0; k < 4; k++) begin
                if (we1[k]) begin
                    mm1[wa1 * 4 + k] = wd1[k*8 +: 8];
                    mk1[wa1 * 4 + k] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic settle();
        idle();
        repeat (LAT - 1) step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        wa0 = '0; wd0 = '0; ra0 = '0; wa1 = '0; wd1 = '0; ra1 = '0;
        clear_model_outputs();
        step();
        step();
        chk("reset_rd0", rd0, 32'h0);
        chk("reset_v0", 32'(v0), 32'h0);
        chk("reset_rd1", 32'(rd1), 32'h0);
        chk("reset_v1", 32'(v1), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            idle();
            we0 = 1'b1; wa0 = 6'(8 + i); wd0 = 8'(8'h11 * (i + 1));
            if (i == 0) begin we1 = 4'b0101; wa1 = 4'd3; wd1 = 32'hDDCCBBAA; end
            if (i == 1) begin we1 = 4'b1111; wa1 = 4'd3; wd1 = 32'h0; end
            if (i == 2) begin we1 = 4'b0101; wa1 = 4'd5; wd1 = 32'hDDCCBBAA; end
            step();
        end

        idle(); re0 = 1'b1; ra0 = 4'd2; re1 = 1'b1; ra1 = 6'd12;
        step();
        settle();
        chk("wide_read_rd0", rd0, 32'h44332211);
        chk("wide_read_v0", 32'(v0), 32'h1);
        chk("overwrite_rd1", 32'(rd1), 32'h0);
        chk("overwrite_v1", 32'(v1), 32'h1);

        idle(); re1 = 1'b1; ra1 = 6'd22;
        step();
        settle();
        chk("masked_lane_rd1", 32'(rd1), 32'hCC);
        idle(); re1 = 1'b1; ra1 = 6'd21;
        step();

        idle(); we0 = 1'b1; wa0 = 6'd20; wd0 = 8'h5A;
        step();
        idle(); we0 = 1'b1; wa0 = 6'd20; wd0 = 8'hA5; re0 = 1'b1; ra0 = 4'd5;
        step();
        settle();
        chk("collision_old", 32'(rd0[7:0]), 32'h5A);
        idle(); re0 = 1'b1; ra0 = 4'd5;
        step();
        settle();
        chk("collision_new", 32'(rd0[7:0]), 32'hA5);

        idle(); re0 = 1'b1; ra0 = 4'd5;
        step();
        for (int i = 0; i < 3; i++) begin
            idle(); we0 = 1'b1; wa0 = 6'd20; wd0 = 8'(i + 1);
            step();
        end
        chk("hold_rd0", 32'(rd0[7:0]), 32'hA5);
        chk("hold_v0", 32'(v0), 32'h0);

        idle(); re0 = 1'b1; ra0 = 4'd2;
        step();
        settle();
        chk("pre_reset_rd0", rd0, 32'h44332211);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_rd0", rd0, 32'h0);
        chk("async_reset_v0", 32'(v0), 32'h0);
        clear_model_outputs();
        idle(); we0 = 1'b1; wa0 = 6'd8; wd0 = 8'hEE;
        step();
        rst_n = 1'b1;
        idle(); re0 = 1'b1; ra0 = 4'd2;
        step();
        settle();
        chk("write_in_reset_ignored", rd0, 32'h44332211);

        for (int i = 0; i < 8; i++) begin
            idle(); we0 = 1'b1; wa0 = 6'(i); wd0 = 8'($urandom);
            step();
        end
        idle(); re0 = 1'b1; ra0 = 4'd2;
        step();
        idle(); re0 = 1'b1; ra0 = 4'd0;
        step();
        idle();
        repeat (2) step();

        for (int n = 0; n < 800; n++) begin
            we0 = 1'($urandom_range(0, 1));
            re0 = 1'($urandom_range(0, 1));
            ra0 = 4'($urandom_range(0, 15));
            wa0 = ($urandom_range(0, 3) == 0) ? 6'(ra0 * 4 + $urandom_range(0, 3))
                                              : 6'($urandom_range(0, 63));
            wd0 = 8'($urandom);
            we1 = 4'($urandom_range(0, 15));
            re1 = 1'($urandom_range(0, 1));
            ra1 = 6'($urandom_range(0, 63));
            wa1 = ($urandom_range(0, 3) == 0) ? 4'(ra1 / 4) : 4'($urandom_range(0, 15));
            wd1 = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/sdp_asym_ram.md
Name: sdp_asym_ram

Overview:
- Parametrised simple-dual-port RAM with asymmetric port widths: one narrow port of DBITS bits and one wide port of RATIO*DBITS bits.
- MODE selects whether the wide side is the read port or the write port.
- Generalises the fixed 1:4 narrow-write/wide-read SDP block: arbitrary power-of-two ratio, either direction, per-lane write mask, read enable with valid flag, optional output register.
- Sits behind the BRAM inference flow as the behavioural golden model and as the wrapper mapped onto QLF TDP36K primitives.

Parameters:
- ABITS, 10, narrow-side address width; memory holds 2^ABITS words of DBITS bits.
- DBITS, 8, narrow word width.
- RATIO_LOG2, 2, log2 of the wide/narrow width ratio; legal range 0..3; RATIO = 2^RATIO_LOG2.
- MODE, 0, 0 = narrow write / wide read; 1 = wide write / narrow read.

Ports:
- clk  input  1  single clock, all activity on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  WE_W  write enable. WE_W = 1 in MODE 0; WE_W = RATIO (per-lane mask) in MODE 1.
- wa  input  WA_W  write address. WA_W = ABITS in MODE 0; ABITS-RATIO_LOG2 in MODE 1.
- wd  input  WD_W  write data. WD_W = DBITS in MODE 0; RATIO*DBITS in MODE 1.
- re  input  1  read enable.
- ra  input  RA_W  read address. RA_W = ABITS-RATIO_LOG2 in MODE 0; ABITS in MODE 1.
- rd  output  RD_W  read data. RD_W = RATIO*DBITS in MODE 0; DBITS in MODE 1.
- rd_valid  output  1  rd holds data from a completed read.

Behaviour:
- Storage: an array of 2^ABITS narrow words. Contents are not reset and power up as X.
- Wide-address mapping: wide address W, lane k maps to narrow address {W, k[RATIO_LOG2-1:0]}. Lane k occupies bits [(k+1)*DBITS-1 : k*DBITS] of the wide bus.
- Write, MODE 0: on the rising edge with we=1, mem[wa] <= wd.
- Write, MODE 1: for each lane k with we[k]=1, mem[{wa,k}] <= wd lane k. Lanes with we[k]=0 are unchanged.
- Read:
  - On the rising edge with re=1, rd <= the addressed word(s); latency 1 cycle.
  - With re=0, rd holds its previous value.
- rd_valid: registered copy of re. Goes high the cycle after an accepted read and low the cycle after re=0.
- Read/write collision (read and write overlap the same narrow word on the same edge): read-first. rd returns the old contents; the new value is visible on the next read.
  - Applies lane by lane: non-overlapping lanes of a wide read are unaffected.
- Reset:
  - While rst_n=0: rd=0, rd_valid=0, writes are ignored.
  - Reset assertion mid-read clears rd and rd_valid asynchronously.
  - First read is accepted on the first rising edge after rst_n deasserts.
- RATIO_LOG2=0 degenerates to a symmetric SDP RAM; both modes are then identical.
- Elaboration error if RATIO_LOG2 > 3 or RATIO_LOG2 >= ABITS.

Optional Feature:
- Macro: SDP_ASYM_OUTREG_EN.
- Defined:
  - A second output register stage is inserted after the array read; read latency is 2 cycles.
  - rd_valid is delayed to match.
  - Both stages reset to 0.
  - The collision rule is still evaluated at the read edge, i.e. the first stage.
- Undefined: latency is 1 cycle, as described above.

Decomposition:
- Package sdp_asym_pkg:
  - mode enum (SDP_NW_WR = 0, SDP_WW_RN = 1).
  - Function lane_addr(wide_addr, lane).
  - Localparam helpers computing WE_W, WA_W, WD_W, RA_W, RD_W from the parameters.
- Sub-module sdp_asym_rd_pipe:
  - Owns the output register(s), the rd_valid pipeline and the optional SDP_ASYM_OUTREG_EN stage, parametrised on RD_W.
  - The top level holds the array, write lane logic and read mux.

Test Plan (ABITS=6, DBITS=8, RATIO_LOG2=2):
- MODE 0: write 0x11,0x22,0x33,0x44 to wa=8..11, then re=1, ra=2 -> next cycle rd=0x44332211, rd_valid=1.
- MODE 1: wa=3, wd=0xDDCCBBAA, we=4'b0101, then we=4'b1111 with wd=0; read narrow ra=12 -> rd=0x00 next cycle. Then, starting from a fresh memory, read after only the first write (we=4'b0101): ra=13 -> X/previous initial value (lane not written); ra=14 -> 0xCC.
- Collision, MODE 0: mem[20]=0x5A; same edge we=1, wa=20, wd=0xA5 and re=1, ra=5 -> rd lane 0 = 0x5A; re-read next cycle -> 0xA5.
- Reset mid-operation: rd=0x44332211, rd_valid=1; pulse rst_n low between edges -> rd=0 and rd_valid=0 immediately. A write attempted during reset is absent on a later read.
- re=0 hold: after a valid read, hold re=0 for 3 cycles while writing the same address -> rd unchanged, rd_valid=0 from the first cycle.
- With SDP_ASYM_OUTREG_EN defined: repeat the first scenario -> rd and rd_valid appear 2 cycles after re; back-to-back reads ra=2,0 give a one-per-cycle stream in order.
